// File: rtl/alu_seq_pkg.sv
// Shared encodings for the digit-serial ALU: operation codes and controller states.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_digit_add.sv
// One DIGIT-wide ripple-carry adder slice used once per cycle by alu_seq.
module alu_digit_add #(
  parameter int unsigned DIGIT = 4
) (
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/alu_seq.sv
// Digit-serial add/subtract ALU: DIGIT bits per cycle, LSB digit first, registered result and flags.
// Build option: define ALU_SEQ_ADC_EN to make op 10/11 chain from the stored carry flag (ADC/SBC).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic             sign,
  output logic             zero,
  output logic             carry,
  output logic             parity,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_e           state, state_nx;
  logic [WIDTH-1:0] xs, ys, zs;
  logic             cy, xm, ym;
  logic [CW-1:0]    cnt;
  logic             ld_c, step_c, last_c;
  logic             sub_c, cin0_c;
  logic [WIDTH-1:0] yeff_c;
  logic [DIGIT-1:0] dsum_c;
  logic             dcout_c;
  logic [WIDTH+DIGIT-1:0] zcat_c;
  logic [WIDTH-1:0] znx_c;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Controller: load on accepted start, then step one digit per cycle.
  always_comb begin
    state_nx = state;
    ld_c     = 1'b0;
    step_c   = 1'b0;
    last_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          ld_c     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (cnt == CW'(N - 1)) begin
          last_c   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy   = (state == RUN);
  assign sub_c  = (op == OP_SUB) || (op == OP_SBC);
  assign yeff_c = sub_c ? ~Y : Y;

`ifdef ALU_SEQ_ADC_EN
  assign cin0_c = op[1] ? carry : sub_c;
`else
  assign cin0_c = sub_c;
`endif

  alu_digit_add #(.DIGIT(DIGIT)) u_digit (
    .sum  (dsum_c),
    .cout (dcout_c),
    .a    (xs[DIGIT-1:0]),
    .b    (ys[DIGIT-1:0]),
    .cin  (cy)
  );

  // New digit enters at the top; after N steps the word is aligned.
  assign zcat_c = {dsum_c, zs};
  assign znx_c  = zcat_c[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      xs       <= '0;
      ys       <= '0;
      zs       <= '0;
      cy       <= 1'b0;
      xm       <= 1'b0;
      ym       <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      Z        <= '0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      parity   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= last_c;
      if (ld_c) begin
        xs  <= X;
        ys  <= yeff_c;
        zs  <= '0;
        cy  <= cin0_c;
        xm  <= X[WIDTH-1];
        ym  <= yeff_c[WIDTH-1];
        cnt <= '0;
      end else if (step_c) begin
        xs  <= xs >> DIGIT;
        ys  <= ys >> DIGIT;
        zs  <= znx_c;
        cy  <= dcout_c;
        cnt <= cnt + CW'(1);
        if (last_c) begin
          Z        <= znx_c;
          sign     <= znx_c[WIDTH-1];
          zero     <= (znx_c == '0);
          carry    <= dcout_c;
          parity   <= ~^znx_c;
          overflow <= (xm == ym) && (znx_c[WIDTH-1] != xm);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16, DIGIT=4) against a whole-word arithmetic model.
module tb_alu_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DIGIT = 4;
`ifdef ALU_SEQ_ADC_EN
  localparam bit ADC_EN = 1'b1;
`else
  localparam bit ADC_EN = 1'b0;
`endif

  logic        clk, rst, start;
  logic [1:0]  op;
  logic [15:0] X, Y, Z;
  logic        busy, done, sign, zero, carry, parity, overflow;

  int n_chk  = 0;
  int n_pass = 0;
  logic mc = 1'b0;

  alu_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .X        (X),
    .Y        (Y),
    .busy     (busy),
    .done     (done),
    .Z        (Z),
    .sign     (sign),
    .zero     (zero),
    .carry    (carry),
    .parity   (parity),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [4:0] flags_now();
    return {sign, zero, carry, parity, overflow};
  endfunction

  // Whole-word reference: flags ordered {sign, zero, carry, parity, overflow}.
  function automatic void model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                input logic cf, output logic [15:0] z, output logic [4:0] fl);
    logic [15:0] b;
    logic        ci;
    logic [16:0] s;
    b  = o[0] ? ~y : y;
    ci = (ADC_EN && o[1]) ? cf : o[0];
    s  = {1'b0, x} + {1'b0, b} + 17'(ci);
    z  = s[15:0];
    fl = {z[15], z == 16'h0, s[16], ~^z, (x[15] == b[15]) && (z[15] != x[15])};
  endfunction

  // Issue one operation from the current cycle, wait for done, compare with the model.
  task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] zo, output logic [4:0] flo);
    logic [15:0] ez;
    logic [4:0]  ef;
    int          cyc;
    model(o, x, y, mc, ez, ef);
    start = 1'b1; op = o; X = x; Y = y;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 20);
    chk("done_latency", 32'(cyc), 32'd4);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("z_model", 32'(Z), 32'(ez));
    chk("flags_model", 32'(flags_now()), 32'(ef));
    zo  = Z;
    flo = flags_now();
    mc  = ef[2];
  endtask

  initial begin
    logic [15:0] z, ez, hold_z;
    logic [4:0]  fl, ef;
    int          ndone;
    logic [15:0] zdone;

    rst = 1'b1; start = 1'b0; op = 2'b00; X = '0; Y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_z", 32'(Z), 32'd0);
    chk("reset_flags", 32'(flags_now()), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(2'b00, 16'h7FFF, 16'h0001, z, fl);
    chk("add_7fff_z", 32'(z), 32'h8000);
    chk("add_7fff_flags", 32'(fl), 32'b10001);

    run_op(2'b00, 16'hFFFF, 16'h0001, z, fl);
    chk("add_ffff_z", 32'(z), 32'h0000);
    chk("add_ffff_flags", 32'(fl), 32'b01110);

    run_op(2'b01, 16'h0005, 16'h0007, z, fl);
    chk("sub_5_7_z", 32'(z), 32'hFFFE);
    chk("sub_5_7_flags", 32'(fl), 32'b10000);

    run_op(2'b01, 16'h0005, 16'h0005, z, fl);
    chk("sub_5_5_z", 32'(z), 32'h0000);
    chk("sub_5_5_flags", 32'(fl), 32'b01110);

    run_op(2'b00, 16'hFFFF, 16'h0001, z, fl);
    run_op(2'b10, 16'h0000, 16'h0000, z, fl);
    chk("adc_chain_z", 32'(z), ADC_EN ? 32'h0001 : 32'h0000);

    // Results must hold while idle.
    hold_z = Z;
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_z", 32'(Z), 32'(hold_z));
      chk("hold_no_done", 32'(done), 32'd0);
    end

    // Start during RUN cycle 2 is ignored.
    model(2'b00, 16'h1111, 16'h2222, mc, ez, ef);
    start = 1'b1; op = 2'b00; X = 16'h1111; Y = 16'h2222;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1; op = 2'b01; X = 16'hFFFF; Y = 16'h0F0F;
    ndone = 0; zdone = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin ndone++; zdone = Z; end
    end
    chk("ignore_done_count", 32'(ndone), 32'd1);
    chk("ignore_z", 32'(zdone), 32'(ez));
    chk("ignore_flags", 32'(flags_now()), 32'(ef));
    mc = ef[2];

    // Reset at RUN cycle 2 aborts the operation.
    start = 1'b1; op = 2'b00; X = 16'h1234; Y = 16'h4321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_z", 32'(Z), 32'd0);
    chk("abort_flags", 32'(flags_now()), 32'd0);
    mc = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    run_op(2'b00, 16'h1234, 16'h4321, z, fl);
    chk("after_abort_z", 32'(z), 32'h5555);

    // Randomized back-to-back operations.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] rx, ry;
      rx = 16'($urandom);
      ry = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rx = 16'hFFFF;
      if ($urandom_range(0, 3) == 0) ry = ($urandom_range(0, 1) == 1) ? 16'h0000 : 16'h8000;
      run_op(2'($urandom_range(0, 3)), rx, ry, z, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, and N = WIDTH/DIGIT.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request a new operation.
REQ-006 SHALL have port op, input, 2 bits: 00 ADD, 01 SUB, 10 ADC, 11 SBC.
REQ-007 SHALL have ports X and Y, input, WIDTH bits each: operands.
REQ-008 SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking valid Z and flags.
REQ-010 SHALL have port Z, output, WIDTH bits: registered result.
REQ-011 SHALL have ports sign, zero, carry, parity and overflow, output, 1 bit each: registered flags.

Function
REQ-012 SHALL accept start only when busy=0, and SHALL capture X, Y and op at that edge.
REQ-013 SHALL ignore start while busy=1; captured operands and op stay unchanged.
REQ-014 SHALL use states IDLE and RUN:
- IDLE to RUN on accepted start.
- RUN to IDLE after N digit cycles.
REQ-015 SHALL process digit i (bits i*DIGIT+DIGIT-1 : i*DIGIT), LSB digit first, one digit per cycle, and register the carry between digits.
REQ-016 SHALL set the initial carry-in as follows:
- ADD: 0.
- SUB: 1.
- ADC and SBC: the current carry flag.
REQ-017 SHALL use Y inverted for SUB and SBC, and Y as given for ADD and ADC.
REQ-018 SHALL assert busy from the edge that accepts start until the edge that completes the last digit (N cycles).
REQ-019 SHALL, at the edge completing the last digit, update Z and all flags, drive busy=0, and drive done=1 for exactly one cycle.
REQ-020 SHALL allow a new start in the done cycle; it SHALL be accepted with no idle gap.
REQ-021 SHALL hold Z and the flags between done pulses.
REQ-022 SHALL compute the flags as follows:
- sign = Z[WIDTH-1].
- zero = (Z == 0).
- parity = XNOR of all Z bits (1 when Z has an even number of ones).
- carry = carry out of the MSB digit; for SUB/SBC, 1 means no borrow.
- overflow = signed overflow: operand MSBs (X, effective Y) equal and Z MSB different.
REQ-023 SHALL keep results modulo 2^WIDTH, with the carry-out as the only extension bit.

Reset
REQ-024 SHALL, when rst=1 at a rising edge, clear Z and all flags, set busy=0 and done=0, and enter IDLE.
REQ-025 SHALL abort an in-progress operation on reset, produce no done pulse for it, and SHALL take priority over a simultaneous start.

Configuration
REQ-026 SHALL provide macro ALU_SEQ_ADC_EN:
- Defined: op 10/11 behave as ADC/SBC, with carry-in taken from the stored carry flag.
- Undefined: op 10 SHALL behave as ADD and op 11 as SUB, and no carry-flag feedback path SHALL exist.

Structure
REQ-027 SHALL place the op encodings (ADD, SUB, ADC, SBC) and the state encoding (IDLE, RUN) in shared package alu_seq_pkg.
REQ-028 SHALL implement the per-digit ripple adder as sub-module alu_digit_add (parameter DIGIT; ports sum, cout, a, b, cin).

Verification (WIDTH=16, DIGIT=4)
REQ-029 SHALL cover ADD 0x7FFF + 0x0001: done 4 cycles after start with Z=0x8000, sign=1, overflow=1, carry=0, zero=0, parity=0.
REQ-030 SHALL cover ADD 0xFFFF + 0x0001: Z=0x0000, carry=1, zero=1, parity=1, overflow=0.
REQ-031 SHALL cover SUB 0x0005 - 0x0007: Z=0xFFFE, carry=0 (borrow), sign=1, overflow=0. SUB 0x0005 - 0x0005 SHALL give Z=0, zero=1, carry=1.
REQ-032 SHALL cover ADD 0xFFFF + 0x0001 followed by ADC 0x0000 + 0x0000:
- With ALU_SEQ_ADC_EN: Z=0x0001.
- Without ALU_SEQ_ADC_EN: Z=0x0000.
REQ-033 SHALL cover a start pulse at RUN cycle 2 with different operands: it is ignored, and exactly one done occurs with the first result.
REQ-034 SHALL cover rst asserted at RUN cycle 2: the next cycle has busy=0, Z=0, all flags 0, and no done. A start afterwards SHALL complete normally.
